// File: rtl/sched_mon_pkg.sv
// Shared types, parameter defaults and the saturating-increment helper
// used by sched_path_monitor and its counters.
package sched_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_CHECK  = 2'd3
    } state_t;

    localparam int NPATHS_DEF   = 4;
    localparam int SETTLE_W_DEF = 4;
    localparam int CNT_W_DEF    = 8;

    // The caller's all-ones mask sets the counter width; the count holds at the mask value.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] mask);
        logic [31:0] m;
        m = v & mask;
        return (m == mask) ? m : ((m + 32'd1) & mask);
    endfunction

endpackage

// File: rtl/sched_sat_counter.sv
// Saturating up-counter with a synchronous clear that has priority over inc.
module sched_sat_counter
    import sched_mon_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] ONES = '1;

    logic [W-1:0] q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc) begin
            q_d = W'(sat_inc(32'(q_q), 32'(ONES)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/sched_path_monitor.sv
// Drives one stimulus bit into parallel paths, checks their settled outputs and keeps
// per-path / trial statistics. Optional glitch detection: SCHED_PATH_MONITOR_GLITCH_EN.
module sched_path_monitor
    import sched_mon_pkg::*;
#(
    parameter int NPATHS   = NPATHS_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stim,
    input  logic [SETTLE_W-1:0]     settle,
    output logic                    ready,
    output logic                    drive,
    input  logic [NPATHS-1:0]       obs,
    output logic                    done,
    output logic [NPATHS-1:0]       fail_mask,
    output logic                    fail_any,
    output logic [NPATHS*CNT_W-1:0] path_cnt,
    output logic [CNT_W-1:0]        trial_cnt,
`ifdef SCHED_PATH_MONITOR_GLITCH_EN
    output logic [NPATHS-1:0]       glitch_mask,
`endif
    input  logic                    clr
);

    state_t                state_q, state_d;
    logic                  ready_q, ready_d;
    logic                  stim_q, stim_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic                  drive_q, drive_d;
    logic                  done_q, done_d;
    logic [NPATHS-1:0]     fail_mask_q, fail_mask_d;
    logic                  fail_any_q, fail_any_d;
    logic                  check;

`ifdef SCHED_PATH_MONITOR_GLITCH_EN
    logic [NPATHS-1:0]       obs_prev_q, obs_prev_d;
    logic [NPATHS-1:0][1:0]  trans_q, trans_d;
    logic [NPATHS-1:0]       glitch_q, glitch_d;
`endif

    assign check = (state_q == ST_CHECK);

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        settle_d    = settle_q;
        cnt_d       = cnt_q;
        drive_d     = drive_q;
        done_d      = 1'b0;
        fail_mask_d = fail_mask_q;
        fail_any_d  = fail_any_q;
`ifdef SCHED_PATH_MONITOR_GLITCH_EN
        obs_prev_d  = obs;
        trans_d     = trans_q;
        glitch_d    = glitch_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef SCHED_PATH_MONITOR_GLITCH_EN
                trans_d = '0;
`endif
                if (start && ready_q) begin
                    stim_d   = stim;
                    settle_d = settle;
                    state_d  = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                drive_d = stim_q;
                cnt_d   = (settle_q == '0) ? SETTLE_W'(1) : settle_q;
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_q <= SETTLE_W'(1)) state_d = ST_CHECK;
                else                       cnt_d   = cnt_q - SETTLE_W'(1);
            end
            default: begin
                fail_mask_d = obs ^ {NPATHS{stim_q}};
                fail_any_d  = |fail_mask_d;
`ifdef SCHED_PATH_MONITOR_GLITCH_EN
                for (int unsigned i = 0; i < NPATHS; i++) begin
                    glitch_d[i] = (trans_q[i] > 2'd1);
                end
                fail_any_d = |(fail_mask_d | glitch_d);
`endif
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
`ifdef SCHED_PATH_MONITOR_GLITCH_EN
        if (state_q == ST_DRIVE || state_q == ST_SETTLE) begin
            for (int unsigned i = 0; i < NPATHS; i++) begin
                if (obs[i] != obs_prev_q[i] && trans_q[i] != 2'd3) begin
                    trans_d[i] = trans_q[i] + 2'd1;
                end
            end
        end
`endif
        // ready stays low through the done cycle so a start there is not taken
        ready_d = (state_d == ST_IDLE) && (state_q != ST_CHECK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ready_q     <= 1'b1;
            stim_q      <= 1'b0;
            settle_q    <= '0;
            cnt_q       <= '0;
            drive_q     <= 1'b0;
            done_q      <= 1'b0;
            fail_mask_q <= '0;
            fail_any_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            stim_q      <= stim_d;
            settle_q    <= settle_d;
            cnt_q       <= cnt_d;
            drive_q     <= drive_d;
            done_q      <= done_d;
            fail_mask_q <= fail_mask_d;
            fail_any_q  <= fail_any_d;
        end
    end

`ifdef SCHED_PATH_MONITOR_GLITCH_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obs_prev_q <= '0;
            trans_q    <= '0;
            glitch_q   <= '0;
        end else begin
            obs_prev_q <= obs_prev_d;
            trans_q    <= trans_d;
            glitch_q   <= glitch_d;
        end
    end

    assign glitch_mask = glitch_q;
`endif

    for (genvar g = 0; g < NPATHS; g++) begin : g_path
        sched_sat_counter #(.W(CNT_W)) u_path_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (check && fail_mask_d[g]),
            .clr   (clr),
            .q     (path_cnt[g*CNT_W +: CNT_W])
        );
    end

    sched_sat_counter #(.W(CNT_W)) u_trial_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (check),
        .clr   (clr),
        .q     (trial_cnt)
    );

    assign ready     = ready_q;
    assign drive     = drive_q;
    assign done      = done_q;
    assign fail_mask = fail_mask_q;
    assign fail_any  = fail_any_q;

endmodule

// File: tb/tb_sched_path_monitor.sv
// Directed bench for sched_path_monitor; glitch steps build with SCHED_PATH_MONITOR_GLITCH_EN.
module tb_sched_path_monitor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stim;
    logic [3:0]  settle;
    logic        ready;
    logic        drive;
    logic [3:0]  obs;
    logic        done;
    logic [3:0]  fail_mask;
    logic        fail_any;
    logic [31:0] path_cnt;
    logic [7:0]  trial_cnt;
    logic        clr;
`ifdef SCHED_PATH_MONITOR_GLITCH_EN
    logic [3:0]  glitch_mask;
`endif

    logic [3:0]  follow_q = 4'b0000;
    logic [3:0]  stuck0 = 4'b0000;
    logic        manual_en = 1'b0;
    logic [3:0]  manual_obs = 4'b0000;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Paths under test: each follows drive one cycle late, optionally stuck at 0.
    always @(posedge clk) follow_q <= {4{drive}};
    assign obs = manual_en ? manual_obs : (follow_q & ~stuck0);

    sched_path_monitor #(.NPATHS(4), .SETTLE_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stim      (stim),
        .settle    (settle),
        .ready     (ready),
        .drive     (drive),
        .obs       (obs),
        .done      (done),
        .fail_mask (fail_mask),
        .fail_any  (fail_any),
        .path_cnt  (path_cnt),
        .trial_cnt (trial_cnt),
`ifdef SCHED_PATH_MONITOR_GLITCH_EN
        .glitch_mask (glitch_mask),
`endif
        .clr       (clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Launch a trial from a sample point; poke_* pulse start/clr during cycle k.
    task automatic trial(input logic s, input logic [3:0] st, input int lat,
                         input int poke_start, input int poke_clr, input string tag);
        int   first;
        int   pulses;
        logic rdy_done;
        logic rdy_after;
        chk({tag, ".ready_pre"}, ready, 1);
        stim   = s;
        settle = st;
        start  = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        first     = -1;
        pulses    = 0;
        rdy_done  = 1'bx;
        rdy_after = 1'bx;
        for (int k = 1; k <= lat + 4; k++) begin
            start = (k == poke_start);
            clr   = (k == poke_clr);
            @(posedge clk); #1;
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first    = k;
                    rdy_done = ready;
                end
            end
            if (k == lat + 1) rdy_after = ready;
        end
        start = 1'b0;
        clr   = 1'b0;
        chk({tag, ".latency"}, first, lat);
        chk({tag, ".pulses"}, pulses, 1);
        chk({tag, ".ready_at_done"}, rdy_done, 0);
        chk({tag, ".ready_after"}, rdy_after, 1);
    endtask

    task automatic idle_watch(input int n, input string tag);
        int pulses = 0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk({tag, ".no_done"}, pulses, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stim   = 1'b0;
        settle = 4'd0;
        clr    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst.ready", ready, 1);
        chk("rst.drive", drive, 0);
        chk("rst.done", done, 0);
        chk("rst.fail_mask", fail_mask, 0);
        chk("rst.fail_any", fail_any, 0);
        chk("rst.path_cnt", path_cnt, 0);
        chk("rst.trial_cnt", trial_cnt, 0);
        idle_watch(20, "idle");

        // Clean trial; start held in the done cycle must be ignored
        trial(1'b1, 4'd3, 5, 6, 0, "clean");
        chk("clean.fail_mask", fail_mask, 4'b0000);
        chk("clean.fail_any", fail_any, 0);
        chk("clean.trial_cnt", trial_cnt, 1);
        chk("clean.drive", drive, 1);
        chk("clean.path_cnt", path_cnt, 0);

        // Path 2 stuck at 0
        stuck0 = 4'b0100;
        trial(1'b1, 4'd2, 4, 0, 0, "stuck");
        chk("stuck.fail_mask", fail_mask, 4'b0100);
        chk("stuck.fail_any", fail_any, 1);
        chk("stuck.path_cnt2", path_cnt[23:16], 1);
        chk("stuck.path_cnt0", path_cnt[7:0], 0);
        chk("stuck.trial_cnt", trial_cnt, 2);
        for (int i = 0; i < 300; i++) trial(1'b1, 4'd2, 4, 0, 0, "sat");
        chk("sat.path_cnt2", path_cnt[23:16], 255);
        chk("sat.path_cnt1", path_cnt[15:8], 0);
        chk("sat.trial_cnt", trial_cnt, 255);

        // Clear, then settle=0 behaves as settle=1
        stuck0 = 4'b0000;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        chk("clr.path_cnt", path_cnt, 0);
        chk("clr.trial_cnt", trial_cnt, 0);
        trial(1'b1, 4'd0, 3, 0, 0, "settle0");
        chk("settle0.fail_mask", fail_mask, 4'b0000);
        chk("settle0.trial_cnt", trial_cnt, 1);
        trial(1'b1, 4'd1, 3, 0, 0, "settle1");
        chk("settle1.trial_cnt", trial_cnt, 2);

        // start during SETTLE is ignored
        trial(1'b1, 4'd4, 6, 2, 0, "busy");
        idle_watch(10, "busy");
        chk("busy.trial_cnt", trial_cnt, 3);

        // clr coincident with a mismatching CHECK
        stuck0 = 4'b0001;
        trial(1'b1, 4'd2, 4, 0, 0, "acc");
        chk("acc.path_cnt0", path_cnt[7:0], 1);
        chk("acc.trial_cnt", trial_cnt, 4);
        trial(1'b1, 4'd2, 4, 0, 4, "clrchk");
        chk("clrchk.fail_mask", fail_mask, 4'b0001);
        chk("clrchk.fail_any", fail_any, 1);
        chk("clrchk.path_cnt", path_cnt, 0);
        chk("clrchk.trial_cnt", trial_cnt, 0);
        stuck0 = 4'b0000;

        // Reset during SETTLE
        stim   = 1'b1;
        settle = 4'd5;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("midrst.drive_pre", drive, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst.ready", ready, 1);
        chk("midrst.drive", drive, 0);
        chk("midrst.done", done, 0);
        chk("midrst.fail_mask", fail_mask, 0);
        chk("midrst.fail_any", fail_any, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        idle_watch(12, "midrst");

`ifdef SCHED_PATH_MONITOR_GLITCH_EN
        begin
            int first = -1;
            manual_en  = 1'b1;
            manual_obs = 4'b1101;
            @(posedge clk); #1;
            stim   = 1'b1;
            settle = 4'd4;
            start  = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 1; k <= 10; k++) begin
                manual_obs = (k == 2) ? 4'b1101 : 4'b1111;
                @(posedge clk); #1;
                if (done && first < 0) first = k;
            end
            chk("glitch.latency", first, 6);
            chk("glitch.fail_mask", fail_mask, 4'b0000);
            chk("glitch.glitch_mask", glitch_mask, 4'b0010);
            chk("glitch.fail_any", fail_any, 1);
            manual_en = 1'b0;
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
